// File: rtl/onehot_ring_sequencer.sv
// onehot_ring_sequencer
// A single set bit circulates through a ring of STAGES flops, holding each
// stage for dwell+1 enabled cycles. Multi-hot corruption is detected and the
// ring recovers to idle. All outputs come straight from flops.
module onehot_ring_sequencer #(
    parameter int STAGES  = 3,
    parameter int DWELL_W = 4,
    localparam int IDX_W  = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load_start,
    input  logic                flush,
    input  logic                enable,
    input  logic                dir,
    input  logic [DWELL_W-1:0]  dwell,
    output logic [STAGES-1:0]   state,
    output logic [IDX_W-1:0]    stage_idx,
    output logic                active,
    output logic                wrap,
    output logic                onehot_err
);

    logic [STAGES-1:0]  state_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               active_q;
    logic               wrap_q;
    logic               err_q;

    logic [STAGES-1:0]  state_n;
    logic [DWELL_W-1:0] cnt_n;
    logic [IDX_W-1:0]   idx_n;
    logic               wrap_n;
    logic               err_n;

    logic [STAGES-1:0]  rot_fwd;
    logic [STAGES-1:0]  rot_rev;
    logic               multi_hot;
    logic               ring_active;

    // Rotated candidates and the corruption test (x & (x-1) is nonzero only
    // when two or more bits are set; all-zero idle is not an error).
    always_comb begin
        rot_fwd     = {state_q[STAGES-2:0], state_q[STAGES-1]};
        rot_rev     = {state_q[0], state_q[STAGES-1:1]};
        multi_hot   = |(state_q & (state_q - {{(STAGES-1){1'b0}}, 1'b1}));
        ring_active = |state_q;
    end

    // Next-state selection in priority order: corruption, flush, load, advance, hold.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        wrap_n  = 1'b0;
        err_n   = 1'b0;
        if (multi_hot) begin
            state_n = '0;
            cnt_n   = '0;
            err_n   = 1'b1;
        end else if (flush) begin
            state_n = '0;
            cnt_n   = '0;
        end else if (load_start) begin
            state_n = {{(STAGES-1){1'b0}}, 1'b1};
            cnt_n   = '0;
        end else if (ring_active && enable) begin
            if (cnt_q >= dwell) begin
                cnt_n = '0;
                if (dir) begin
                    state_n = rot_rev;
                    wrap_n  = state_q[0];
                end else begin
                    state_n = rot_fwd;
                    wrap_n  = state_q[STAGES-1];
                end
            end else begin
                cnt_n = cnt_q + {{(DWELL_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Binary index of the next one-hot vector, 0 when idle.
    always_comb begin
        idx_n = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (state_n[i]) begin
                idx_n = IDX_W'(i);
            end
        end
    end

    // State, counter and registered copies of every output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            idx_q    <= idx_n;
            active_q <= |state_n;
            wrap_q   <= wrap_n;
            err_q    <= err_n;
        end
    end

    assign state      = state_q;
    assign stage_idx  = idx_q;
    assign active     = active_q;
    assign wrap       = wrap_q;
    assign onehot_err = err_q;

endmodule
